// File: rtl/dac_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dac_mon_pkg
// Brief   : Shared frame layout, command codes and FSM states for the DAC
//           serial monitor.
// Revision: 1.0
// ============================================================================
package dac_mon_pkg;

   localparam int CMD_LSB  = 24;
   localparam int ADDR_LSB = 20;
   localparam int DATA_LSB = 4;
   localparam int FIELD_W  = 4;

   localparam logic [3:0] CMD_WR     = 4'h0;
   localparam logic [3:0] CMD_UPD    = 4'h2;
   localparam logic [3:0] CMD_WR_UPD = 4'h3;
   localparam logic [3:0] CMD_RESET  = 4'h7;
   localparam logic [3:0] ADDR_ALL   = 4'hF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      WAIT_HIGH = 2'd2
   } state_t;

endpackage : dac_mon_pkg
`default_nettype wire

// File: rtl/dac_mon_sync.sv
`default_nettype none
// ============================================================================
// Module  : dac_mon_sync
// Brief   : Two-flop synchronizer plus an edge-detect stage with rise/fall
//           pulses.
// Revision: 1.0
// ============================================================================
module dac_mon_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [2:0] r_stage;

   // Stages reset low so a line already low at reset release produces no fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stage <= 3'b000;
      end else begin
         r_stage <= {r_stage[1:0], async_in};
      end
   end

   assign sync_out = r_stage[1];
   assign rise     =  r_stage[1] & ~r_stage[2];
   assign fall     = ~r_stage[1] &  r_stage[2];

endmodule : dac_mon_sync
`default_nettype wire

// File: rtl/dac_serial_monitor.sv
`default_nettype none
// ============================================================================
// Module  : dac_serial_monitor
// Brief   : Passive DAC serial-frame decoder with channel shadow and sticky
//           error flags. Shadow storage built only with DAC_MON_SHADOW_EN.
// Revision: 1.0
// ============================================================================
module dac_serial_monitor
   import dac_mon_pkg::*;
#(
   parameter int FRAME_BITS = 32,
   parameter int N_CH       = 8,
   parameter int DATA_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dac_sclk,
   input  logic              dac_nsync,
   input  logic              dac_din,
   output logic              frame_valid,
   output logic [3:0]        frame_cmd,
   output logic [3:0]        frame_addr,
   output logic [DATA_W-1:0] frame_data,
   input  logic [2:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              err_short,
   output logic              err_long,
   output logic              err_addr,
   input  logic              err_clr,
   output logic [15:0]       frame_cnt
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FRAME_BITS);

   logic w_sclk_s, w_sclk_rise, w_sclk_fall;
   logic w_nsync_s, w_nsync_rise, w_nsync_fall;
   logic w_din_s, w_din_rise, w_din_fall;

   dac_mon_sync u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .async_in(dac_sclk),
      .sync_out(w_sclk_s), .rise(w_sclk_rise), .fall(w_sclk_fall));

   dac_mon_sync u_sync_nsync (
      .clk(clk), .reset_n(reset_n), .async_in(dac_nsync),
      .sync_out(w_nsync_s), .rise(w_nsync_rise), .fall(w_nsync_fall));

   dac_mon_sync u_sync_din (
      .clk(clk), .reset_n(reset_n), .async_in(dac_din),
      .sync_out(w_din_s), .rise(w_din_rise), .fall(w_din_fall));

   state_t                r_state, w_state_next;
   logic [CNT_W-1:0]      r_bit_cnt, w_cnt_next;
   logic [FRAME_BITS-1:0] r_shreg, w_shreg_next;
   logic w_start, w_shift, w_set_long, w_decode, w_set_short;

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= WAIT_HIGH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_nsync_fall) w_state_next = SHIFT;
         end
         SHIFT: begin
            if (w_sclk_fall && (r_bit_cnt == C_FULL)) w_state_next = WAIT_HIGH;
            else if (w_nsync_rise)                    w_state_next = IDLE;
         end
         WAIT_HIGH: begin
            if (w_nsync_s) w_state_next = IDLE;
         end
         default: w_state_next = WAIT_HIGH;
      endcase
   end

   // FSM: outputs; end-of-frame tests see the count after this sample's shift
   always_comb begin
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_set_long  = 1'b0;
      w_decode    = 1'b0;
      w_set_short = 1'b0;
      case (r_state)
         IDLE: w_start = w_nsync_fall;
         SHIFT: begin
            w_set_long = w_sclk_fall && (r_bit_cnt == C_FULL);
            w_shift    = w_sclk_fall && (r_bit_cnt != C_FULL);
            if (!w_set_long && w_nsync_rise) begin
               w_decode    = (w_cnt_next == C_FULL);
               w_set_short = (w_cnt_next != C_FULL);
            end
         end
         default: ;
      endcase
   end

   assign w_cnt_next   = w_shift ? r_bit_cnt + 1'b1 : r_bit_cnt;
   assign w_shreg_next = w_shift ? {r_shreg[FRAME_BITS-2:0], w_din_s} : r_shreg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt <= '0;
         r_shreg   <= '0;
      end else if (w_start) begin
         r_bit_cnt <= '0;
         r_shreg   <= '0;
      end else begin
         r_bit_cnt <= w_cnt_next;
         r_shreg   <= w_shreg_next;
      end
   end

   logic [3:0]        w_cmd, w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_cmd_wr, w_cmd_rst, w_addr_all;

   assign w_cmd      = w_shreg_next[CMD_LSB  +: FIELD_W];
   assign w_addr     = w_shreg_next[ADDR_LSB +: FIELD_W];
   assign w_data     = w_shreg_next[DATA_LSB +: DATA_W];
   assign w_cmd_wr   = (w_cmd == CMD_WR) || (w_cmd == CMD_UPD) || (w_cmd == CMD_WR_UPD);
   assign w_cmd_rst  = (w_cmd == CMD_RESET);
   assign w_addr_all = (w_addr == ADDR_ALL);

   logic              r_frame_valid;
   logic [3:0]        r_frame_cmd, r_frame_addr;
   logic [DATA_W-1:0] r_frame_data;
   logic [15:0]       r_frame_cnt;
   logic              r_err_short, r_err_long;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_valid <= 1'b0;
         r_frame_cmd   <= '0;
         r_frame_addr  <= '0;
         r_frame_data  <= '0;
         r_frame_cnt   <= '0;
         r_err_short   <= 1'b0;
         r_err_long    <= 1'b0;
      end else begin
         r_frame_valid <= w_decode;
         if (w_decode) begin
            r_frame_cmd  <= w_cmd;
            r_frame_addr <= w_addr;
            r_frame_data <= w_data;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
         end
         // A new error in the clear cycle still lands.
         r_err_short <= (r_err_short & ~err_clr) | w_set_short;
         r_err_long  <= (r_err_long  & ~err_clr) | w_set_long;
      end
   end

   assign frame_valid = r_frame_valid;
   assign frame_cmd   = r_frame_cmd;
   assign frame_addr  = r_frame_addr;
   assign frame_data  = r_frame_data;
   assign frame_cnt   = r_frame_cnt;
   assign err_short   = r_err_short;
   assign err_long    = r_err_long;

`ifdef DAC_MON_SHADOW_EN
   logic [DATA_W-1:0] r_shadow [N_CH];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_err_addr;
   logic              w_addr_bad;

   assign w_addr_bad = w_decode && w_cmd_wr && !w_addr_all && (w_addr >= 4'(N_CH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) r_shadow[i] <= '0;
      end else if (w_decode) begin
         if (w_cmd_rst) begin
            for (int i = 0; i < N_CH; i++) r_shadow[i] <= '0;
         end else if (w_cmd_wr) begin
            for (int i = 0; i < N_CH; i++) begin
               if (w_addr_all || (w_addr == 4'(i))) r_shadow[i] <= w_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_data  <= '0;
         r_err_addr <= 1'b0;
      end else begin
         r_rd_data  <= r_shadow[rd_addr];
         r_err_addr <= (r_err_addr & ~err_clr) | w_addr_bad;
      end
   end

   assign rd_data  = r_rd_data;
   assign err_addr = r_err_addr;

   logic w_unused;
   assign w_unused = ^{w_shreg_next[FRAME_BITS-1:CMD_LSB+FIELD_W],
                       w_shreg_next[DATA_LSB-1:0],
                       w_sclk_s, w_sclk_rise, w_din_rise, w_din_fall};
`else
   assign rd_data  = '0;
   assign err_addr = 1'b0;

   logic w_unused;
   assign w_unused = ^{w_shreg_next[FRAME_BITS-1:CMD_LSB+FIELD_W],
                       w_shreg_next[DATA_LSB-1:0],
                       w_sclk_s, w_sclk_rise, w_din_rise, w_din_fall,
                       rd_addr, w_cmd_wr, w_cmd_rst, w_addr_all, 8'(N_CH)};
`endif

endmodule : dac_serial_monitor
`default_nettype wire

// File: tb/tb_dac_serial_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_dac_serial_monitor
// Brief   : Randomized self-checking bench against a frame-level reference
//           model. Shadow expectations follow DAC_MON_SHADOW_EN.
// Revision: 1.0
// ============================================================================
module tb_dac_serial_monitor;

`ifdef DAC_MON_SHADOW_EN
   localparam bit SHADOW_EN = 1'b1;
`else
   localparam bit SHADOW_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        dac_sclk = 1'b0, dac_nsync = 1'b1, dac_din = 1'b0, err_clr = 1'b0;
   logic [2:0]  rd_addr = 3'd0;
   logic        frame_valid, err_short, err_long, err_addr;
   logic [3:0]  frame_cmd, frame_addr;
   logic [15:0] frame_data, rd_data, frame_cnt;

   dac_serial_monitor dut (
      .clk(clk), .reset_n(reset_n), .dac_sclk(dac_sclk), .dac_nsync(dac_nsync),
      .dac_din(dac_din), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
      .frame_addr(frame_addr), .frame_data(frame_data), .rd_addr(rd_addr),
      .rd_data(rd_data), .err_short(err_short), .err_long(err_long),
      .err_addr(err_addr), .err_clr(err_clr), .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   int chk = 0, pass = 0, vcount = 0;
   logic [15:0] rd_vals [8];

   // Reference model, updated once per complete transaction
   logic [15:0] m_shadow [8];
   logic [15:0] m_cnt, m_data;
   logic [3:0]  m_cmd, m_addr_f;
   logic        m_short, m_long, m_addr;

   always @(negedge clk) if (frame_valid === 1'b1) vcount = vcount + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_shadow[i] = 16'h0;
      m_cnt = 0; m_data = 0; m_cmd = 0; m_addr_f = 0;
      m_short = 0; m_long = 0; m_addr = 0;
   endtask

   task automatic model_frame(input logic [31:0] w, input int nbits);
      logic [3:0] c, a;
      logic [15:0] d;
      c = w[27:24]; a = w[23:20]; d = w[19:4];
      if (nbits < 32) m_short = 1'b1;
      else if (nbits > 32) m_long = 1'b1;
      else begin
         m_cnt = m_cnt + 16'd1; m_cmd = c; m_addr_f = a; m_data = d;
         if (c == 4'h0 || c == 4'h2 || c == 4'h3) begin
            if (a == 4'hF) for (int i = 0; i < 8; i++) m_shadow[i] = d;
            else if (a < 4'd8) m_shadow[a[2:0]] = d;
            else if (SHADOW_EN) m_addr = 1'b1;
         end else if (c == 4'h7) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = 16'h0;
         end
      end
   endtask

   function automatic logic [15:0] exp_rd(input int i);
      return SHADOW_EN ? m_shadow[i] : 16'h0;
   endfunction

   task automatic shift_bits(input logic [31:0] w, input int n);
      logic [31:0] sh;
      sh = w;
      for (int i = 0; i < n; i++) begin
         dac_din = (i < 32) ? sh[31] : $urandom_range(0, 1);
         sh = sh << 1;
         dac_sclk = 1'b1; repeat (4) @(negedge clk);
         dac_sclk = 1'b0; repeat (4) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [31:0] w, input int nbits);
      dac_nsync = 1'b0; repeat (4) @(negedge clk);
      shift_bits(w, nbits);
      dac_nsync = 1'b1; dac_din = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic read_shadow();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) rd_addr = 3'(i);
         @(negedge clk) rd_vals[i] = rd_data;
      end
   endtask

   task automatic clear_errors();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      m_short = 0; m_long = 0; m_addr = 0;
   endtask

   function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
      return {4'($urandom_range(0, 15)), c, a, d, 4'($urandom_range(0, 15))};
   endfunction

   task automatic test_reset();
      model_reset();
      reset_n = 1'b0; repeat (5) @(negedge clk);
      reset_n = 1'b1; repeat (6) @(negedge clk);
      chk++; if ({frame_valid, frame_cmd, frame_addr, frame_data, frame_cnt} !== 41'd0)
         $display("FAIL reset_frame: got %h, want 0", {frame_valid, frame_cmd, frame_addr, frame_data, frame_cnt});
      else pass++;
      chk++; if ({err_short, err_long, err_addr, rd_data} !== 19'd0)
         $display("FAIL reset_err_rd: got %h, want 0", {err_short, err_long, err_addr, rd_data});
      else pass++;
   endtask

   task automatic test_good_frame();
      int v0;
      logic [31:0] w;
      v0 = vcount; w = mk(4'h3, 4'h2, 16'hABCD);
      send_frame(w, 32); model_frame(w, 32);
      chk++; if (vcount - v0 !== 1) $display("FAIL good_valid: got %0d pulses, want 1", vcount - v0); else pass++;
      chk++; if ({frame_cmd, frame_addr, frame_data} !== {m_cmd, m_addr_f, m_data})
         $display("FAIL good_fields: got %h, want %h", {frame_cmd, frame_addr, frame_data}, {m_cmd, m_addr_f, m_data});
      else pass++;
      chk++; if (frame_cnt !== m_cnt) $display("FAIL good_cnt: got %0d, want %0d", frame_cnt, m_cnt); else pass++;
      chk++; if ({err_short, err_long, err_addr} !== 3'b000)
         $display("FAIL good_errs: got %b, want 000", {err_short, err_long, err_addr});
      else pass++;
      @(negedge clk) rd_addr = 3'd2;
      @(negedge clk);
      chk++; if (rd_data !== exp_rd(2)) $display("FAIL good_rd: got %h, want %h", rd_data, exp_rd(2)); else pass++;
   endtask

   task automatic test_broadcast_reset();
      logic [31:0] w;
      w = mk(4'h3, 4'hF, 16'h1234); send_frame(w, 32); model_frame(w, 32);
      read_shadow();
      for (int i = 0; i < 8; i++) begin
         chk++; if (rd_vals[i] !== exp_rd(i)) $display("FAIL bcast_rd[%0d]: got %h, want %h", i, rd_vals[i], exp_rd(i)); else pass++;
      end
      w = mk(4'h7, 4'h0, 16'h5555); send_frame(w, 32); model_frame(w, 32);
      read_shadow();
      for (int i = 0; i < 8; i++) begin
         chk++; if (rd_vals[i] !== exp_rd(i)) $display("FAIL clr_rd[%0d]: got %h, want %h", i, rd_vals[i], exp_rd(i)); else pass++;
      end
      chk++; if (frame_cnt !== m_cnt) $display("FAIL bcast_cnt: got %0d, want %0d", frame_cnt, m_cnt); else pass++;
   endtask

   task automatic test_short();
      int v0;
      logic [31:0] w;
      v0 = vcount; w = mk(4'h3, 4'h1, 16'hBEEF);
      send_frame(w, 20); model_frame(w, 20);
      chk++; if (err_short !== m_short) $display("FAIL short_flag: got %b, want %b", err_short, m_short); else pass++;
      chk++; if (vcount - v0 !== 0) $display("FAIL short_valid: got %0d pulses, want 0", vcount - v0); else pass++;
      chk++; if (frame_cnt !== m_cnt) $display("FAIL short_cnt: got %0d, want %0d", frame_cnt, m_cnt); else pass++;
      w = mk(4'h0, 4'h5, 16'h0F0F); send_frame(w, 32); model_frame(w, 32);
      chk++; if (vcount - v0 !== 1) $display("FAIL short_next_valid: got %0d pulses, want 1", vcount - v0); else pass++;
      chk++; if (frame_data !== m_data) $display("FAIL short_next_data: got %h, want %h", frame_data, m_data); else pass++;
      chk++; if (err_short !== 1'b1) $display("FAIL short_sticky: got %b, want 1", err_short); else pass++;
      clear_errors();
      chk++; if (err_short !== 1'b0) $display("FAIL short_clr: got %b, want 0", err_short); else pass++;
   endtask

   task automatic test_long();
      int v0;
      bit done, seen;
      logic [31:0] w;
      v0 = vcount; w = mk(4'h3, 4'h4, 16'h7777);
      send_frame(w, 33); model_frame(w, 33);
      chk++; if (err_long !== m_long) $display("FAIL long_flag: got %b, want %b", err_long, m_long); else pass++;
      chk++; if (vcount - v0 !== 0) $display("FAIL long_valid: got %0d pulses, want 0", vcount - v0); else pass++;
      chk++; if (frame_cnt !== m_cnt) $display("FAIL long_cnt: got %0d, want %0d", frame_cnt, m_cnt); else pass++;
      clear_errors();
      chk++; if (err_long !== 1'b0) $display("FAIL long_clr: got %b, want 0", err_long); else pass++;
      // err_clr held high right up to the cycle the new error lands
      done = 0; seen = 0;
      fork
         begin send_frame(w, 33); done = 1; end
         begin
            while (!done && !seen) begin
               @(negedge clk);
               if (err_long === 1'b1) seen = 1;
               else err_clr = 1'b1;
            end
            err_clr = 1'b0;
         end
      join
      m_short = 0; m_addr = 0; m_long = 1;
      repeat (3) @(negedge clk);
      chk++; if (err_long !== 1'b1) $display("FAIL long_set_wins: got %b, want 1", err_long); else pass++;
      clear_errors();
   endtask

   task automatic test_bad_addr();
      int v0;
      logic [31:0] w;
      v0 = vcount; w = mk(4'h3, 4'h9, 16'hC0DE);
      send_frame(w, 32); model_frame(w, 32);
      chk++; if (vcount - v0 !== 1) $display("FAIL badaddr_valid: got %0d pulses, want 1", vcount - v0); else pass++;
      chk++; if (err_addr !== m_addr) $display("FAIL badaddr_flag: got %b, want %b", err_addr, m_addr); else pass++;
      read_shadow();
      for (int i = 0; i < 8; i++) begin
         chk++; if (rd_vals[i] !== exp_rd(i)) $display("FAIL badaddr_rd[%0d]: got %h, want %h", i, rd_vals[i], exp_rd(i)); else pass++;
      end
      clear_errors();
   endtask

   task automatic test_random();
      int v0, nb;
      logic [3:0] c;
      logic [31:0] w;
      for (int it = 0; it < 12; it++) begin
         case ($urandom_range(0, 5))
            0: c = 4'h0; 1: c = 4'h2; 2: c = 4'h3; 3: c = 4'h3; 4: c = 4'h7;
            default: c = 4'($urandom_range(8, 15));
         endcase
         w = mk(c, 4'($urandom_range(0, 15)), 16'($urandom));
         nb = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 31) : 32;
         v0 = vcount;
         send_frame(w, nb); model_frame(w, nb);
         chk++; if ((vcount - v0) !== ((nb == 32) ? 1 : 0)) $display("FAIL rnd%0d_valid: got %0d pulses, nbits %0d", it, vcount - v0, nb); else pass++;
         chk++; if ({frame_cnt, frame_cmd, frame_addr, frame_data} !== {m_cnt, m_cmd, m_addr_f, m_data})
            $display("FAIL rnd%0d_fields: got %h, want %h", it, {frame_cnt, frame_cmd, frame_addr, frame_data}, {m_cnt, m_cmd, m_addr_f, m_data});
         else pass++;
         chk++; if ({err_short, err_long, err_addr} !== {m_short, m_long, m_addr})
            $display("FAIL rnd%0d_errs: got %b, want %b", it, {err_short, err_long, err_addr}, {m_short, m_long, m_addr});
         else pass++;
      end
      read_shadow();
      for (int i = 0; i < 8; i++) begin
         chk++; if (rd_vals[i] !== exp_rd(i)) $display("FAIL rnd_rd[%0d]: got %h, want %h", i, rd_vals[i], exp_rd(i)); else pass++;
      end
   endtask

   task automatic test_reset_midframe();
      int v0;
      logic [31:0] w;
      w = mk(4'h3, 4'h6, 16'h4321);
      dac_nsync = 1'b0; repeat (4) @(negedge clk);
      shift_bits(w, 10);
      reset_n = 1'b0; repeat (3) @(negedge clk);
      reset_n = 1'b1; model_reset();
      v0 = vcount;
      shift_bits(w << 10, 22);
      dac_nsync = 1'b1; dac_din = 1'b0; repeat (10) @(negedge clk);
      chk++; if (vcount - v0 !== 0) $display("FAIL mid_valid: got %0d pulses, want 0", vcount - v0); else pass++;
      chk++; if ({frame_cnt, frame_data, err_short, err_long} !== 34'd0)
         $display("FAIL mid_state: got %h, want 0", {frame_cnt, frame_data, err_short, err_long});
      else pass++;
      send_frame(w, 32); model_frame(w, 32);
      chk++; if (vcount - v0 !== 1) $display("FAIL mid_next_valid: got %0d pulses, want 1", vcount - v0); else pass++;
      chk++; if ({frame_cnt, frame_data} !== {m_cnt, m_data})
         $display("FAIL mid_next_fields: got %h, want %h", {frame_cnt, frame_data}, {m_cnt, m_data});
      else pass++;
      @(negedge clk) rd_addr = 3'd6;
      @(negedge clk);
      chk++; if (rd_data !== exp_rd(6)) $display("FAIL mid_rd: got %h, want %h", rd_data, exp_rd(6)); else pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_broadcast_reset();
      test_short();
      test_long();
      test_bad_addr();
      test_random();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule : tb_dac_serial_monitor
`default_nettype wire
